// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants and the bypass-select encoding for the operand fetch stage.
package operand_fetch_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Source of a resolved operand, listed in decreasing priority.
    typedef enum logic [2:0] {
        ZERO,
        EXFWD,
        MEM,
        WB,
        RF
    } bypass_sel_e;

endpackage

// File: rtl/operand_fetch_stage_bypass_mux.sv
// Per-operand bypass selector: picks x0, an EX-stage late forward, the EX/MEM result,
// the writeback value or the register-file read, in that priority order.
module operand_bypass_mux #(
    parameter int XLEN       = operand_fetch_stage_pkg::XLEN,
    parameter int REG_ADDR_W = operand_fetch_stage_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  ex_fwd_en,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_fwd_en,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic [XLEN-1:0]       rf_data,
    output logic [XLEN-1:0]       operand,
    output logic                  fwd_ex
);
    import operand_fetch_stage_pkg::*;

    bypass_sel_e sel;

    always_comb begin
        sel = RF;
        if (rs == '0)
            sel = ZERO;
        else if (ex_fwd_en && ex_rd == rs)
            sel = EXFWD;
        else if (mem_fwd_en && mem_rd == rs)
            sel = MEM;
        // The register file does not show a same-cycle write on its read port.
        else if (wb_en && wb_addr == rs)
            sel = WB;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        operand = '0;
        fwd_ex  = (sel == EXFWD);
        case (sel)
            MEM:     operand = mem_data;
            WB:      operand = wb_data;
            RF:      operand = rf_data;
            default: operand = '0;
        endcase
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: drives register-file reads, bypasses operands, stalls on
// load-use hazards and registers the result into ID/EX behind a valid/ready handshake.
module operand_fetch_stage #(
    parameter int XLEN       = operand_fetch_stage_pkg::XLEN,
    parameter int REG_ADDR_W = operand_fetch_stage_pkg::REG_ADDR_W,
    parameter int COUNT_W    = 32
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  flush,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [REG_ADDR_W-1:0] inRs1,
    input  logic [REG_ADDR_W-1:0] inRs2,
    input  logic [REG_ADDR_W-1:0] inRd,
    input  logic                  inRdEnable,
    input  logic                  inIsLoad,
    input  logic [XLEN-1:0]       inPc,
    input  logic [XLEN-1:0]       inImm,
    output logic [REG_ADDR_W-1:0] readAddress1,
    output logic [REG_ADDR_W-1:0] readAddress2,
    input  logic [XLEN-1:0]       readData1,
    input  logic [XLEN-1:0]       readData2,
    input  logic                  memValid,
    input  logic                  memRdEnable,
    input  logic                  memIsLoad,
    input  logic [REG_ADDR_W-1:0] memRdAddr,
    input  logic [XLEN-1:0]       memData,
    input  logic                  wbEnable,
    input  logic [REG_ADDR_W-1:0] wbAddr,
    input  logic [XLEN-1:0]       wbData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [XLEN-1:0]       outOperand1,
    output logic [XLEN-1:0]       outOperand2,
    output logic [REG_ADDR_W-1:0] outRd,
    output logic                  outRdEnable,
    output logic                  outIsLoad,
    output logic [XLEN-1:0]       outPc,
    output logic [XLEN-1:0]       outImm,
    output logic                  outFwdEx1,
    output logic                  outFwdEx2,
    output logic [COUNT_W-1:0]    bubbleCount
);
    import operand_fetch_stage_pkg::*;

    logic            advance;
    logic            hazard;
    logic            hazard1;
    logic            hazard2;
    logic            ex_alu;
    logic            ex_load;
    logic            mem_alu;
    logic            mem_load;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            fwd1;
    logic            fwd2;

    assign readAddress1 = inRs1;
    assign readAddress2 = inRs2;

    assign ex_alu   = outValid && outRdEnable && !outIsLoad;
    assign ex_load  = outValid && outRdEnable && outIsLoad;
    assign mem_alu  = memValid && memRdEnable && !memIsLoad;
    assign mem_load = memValid && memRdEnable && memIsLoad;

    // A load's data exists only after MEM, so a consumer waits while it sits in ID/EX or EX/MEM.
    assign hazard1 = (inRs1 != '0) &&
                     ((ex_load && outRd == inRs1) || (mem_load && memRdAddr == inRs1));
    assign hazard2 = (inRs2 != '0) &&
                     ((ex_load && outRd == inRs2) || (mem_load && memRdAddr == inRs2));

    assign advance = !outValid || outReady;
    assign hazard  = inValid && (hazard1 || hazard2);
    assign inReady = advance && !hazard && !flush;

    operand_bypass_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_mux1 (
        .rs         (inRs1),
        .ex_fwd_en  (ex_alu),
        .ex_rd      (outRd),
        .mem_fwd_en (mem_alu),
        .mem_rd     (memRdAddr),
        .mem_data   (memData),
        .wb_en      (wbEnable),
        .wb_addr    (wbAddr),
        .wb_data    (wbData),
        .rf_data    (readData1),
        .operand    (operand1),
        .fwd_ex     (fwd1)
    );

    operand_bypass_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_mux2 (
        .rs         (inRs2),
        .ex_fwd_en  (ex_alu),
        .ex_rd      (outRd),
        .mem_fwd_en (mem_alu),
        .mem_rd     (memRdAddr),
        .mem_data   (memData),
        .wb_en      (wbEnable),
        .wb_addr    (wbAddr),
        .wb_data    (wbData),
        .rf_data    (readData2),
        .operand    (operand2),
        .fwd_ex     (fwd2)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            outValid    <= 1'b0;
            outOperand1 <= '0;
            outOperand2 <= '0;
            outRd       <= '0;
            outRdEnable <= 1'b0;
            outIsLoad   <= 1'b0;
            outPc       <= '0;
            outImm      <= '0;
            outFwdEx1   <= 1'b0;
            outFwdEx2   <= 1'b0;
            bubbleCount <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (advance) begin
            if (inValid && !hazard) begin
                outValid    <= 1'b1;
                outOperand1 <= operand1;
                outOperand2 <= operand2;
                outRd       <= inRd;
                outRdEnable <= inRdEnable;
                outIsLoad   <= inIsLoad;
                outPc       <= inPc;
                outImm      <= inImm;
                outFwdEx1   <= fwd1;
                outFwdEx2   <= fwd2;
            end else begin
                // Bubble or empty slot; payload fields keep stale values behind outValid=0.
                outValid <= 1'b0;
                if (hazard && bubbleCount != '1)
                    bubbleCount <= bubbleCount + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: expected ID/EX payloads go into a scoreboard
// queue and a negedge monitor pops and compares them on every output handshake.
module tb_operand_fetch_stage;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rde;
        logic        isl;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        fwd1;
        logic        fwd2;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetN, flush, inValid, inReady;
    logic [4:0]  inRs1, inRs2, inRd, readAddress1, readAddress2;
    logic        inRdEnable, inIsLoad;
    logic [31:0] inPc, inImm, readData1, readData2;
    logic        memValid, memRdEnable, memIsLoad;
    logic [4:0]  memRdAddr, wbAddr, outRd;
    logic [31:0] memData, wbData;
    logic        wbEnable, outValid, outReady, outRdEnable, outIsLoad, outFwdEx1, outFwdEx2;
    logic [31:0] outOperand1, outOperand2, outPc, outImm;
    logic [1:0]  bubbleCount;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_passed = 0;

    always #5 clock = ~clock;

    operand_fetch_stage #(.XLEN(32), .REG_ADDR_W(5), .COUNT_W(2)) dut (
        .clock        (clock),
        .resetN       (resetN),
        .flush        (flush),
        .inValid      (inValid),
        .inReady      (inReady),
        .inRs1        (inRs1),
        .inRs2        (inRs2),
        .inRd         (inRd),
        .inRdEnable   (inRdEnable),
        .inIsLoad     (inIsLoad),
        .inPc         (inPc),
        .inImm        (inImm),
        .readAddress1 (readAddress1),
        .readAddress2 (readAddress2),
        .readData1    (readData1),
        .readData2    (readData2),
        .memValid     (memValid),
        .memRdEnable  (memRdEnable),
        .memIsLoad    (memIsLoad),
        .memRdAddr    (memRdAddr),
        .memData      (memData),
        .wbEnable     (wbEnable),
        .wbAddr       (wbAddr),
        .wbData       (wbData),
        .outValid     (outValid),
        .outReady     (outReady),
        .outOperand1  (outOperand1),
        .outOperand2  (outOperand2),
        .outRd        (outRd),
        .outRdEnable  (outRdEnable),
        .outIsLoad    (outIsLoad),
        .outPc        (outPc),
        .outImm       (outImm),
        .outFwdEx1    (outFwdEx1),
        .outFwdEx2    (outFwdEx2),
        .bubbleCount  (bubbleCount)
    );

    task automatic check(input string name, input logic [159:0] actual, input logic [159:0] expected);
        n_checks++;
        if (actual === expected)
            n_passed++;
        else
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    function automatic exp_t mk(input logic [31:0] op1, op2, input logic [4:0] rd,
                                input logic rde, isl, input logic [31:0] pc, imm,
                                input logic fwd1, fwd2);
        exp_t e;
        e = '{op1: op1, op2: op2, rd: rd, rde: rde, isl: isl, pc: pc, imm: imm,
              fwd1: fwd1, fwd2: fwd2};
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, rs2, rd, input logic rde, isl,
                         input logic [31:0] pc, imm);
        inValid = 1'b1; inRs1 = rs1; inRs2 = rs2; inRd = rd;
        inRdEnable = rde; inIsLoad = isl; inPc = pc; inImm = imm;
    endtask

    task automatic clear_pipe();
        inValid = 1'b0; memValid = 1'b0; memRdEnable = 1'b0; memIsLoad = 1'b0;
        wbEnable = 1'b0;
    endtask

    // Monitor: every handshake on the output side must match the oldest expectation.
    initial begin
        exp_t act;
        forever begin
            @(negedge clock);
            if (resetN && outValid && outReady) begin
                act = mk(outOperand1, outOperand2, outRd, outRdEnable, outIsLoad,
                         outPc, outImm, outFwdEx1, outFwdEx2);
                if (sb.size() == 0)
                    check("unexpected_output", {23'd0, act}, 160'd0);
                else
                    check("idex_payload", {23'd0, act}, {23'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        resetN = 1'b0; flush = 1'b0; outReady = 1'b1;
        inRs1 = '0; inRs2 = '0; inRd = '0; inRdEnable = 1'b0; inIsLoad = 1'b0;
        inPc = '0; inImm = '0; readData1 = '0; readData2 = '0;
        memRdAddr = '0; memData = '0; wbAddr = '0; wbData = '0;
        clear_pipe();

        #3;
        check("reset_out_valid", outValid, 1'b0);
        check("reset_bubble_count", bubbleCount, 2'd0);
        check("reset_operand1", outOperand1, 32'd0);
        #9 resetN = 1'b1;
        step();

        // WB bypass on rs1, register file on rs2.
        wbEnable = 1'b1; wbAddr = 5'd5; wbData = 32'hDEADBEEF;
        readData1 = 32'h0; readData2 = 32'h1234;
        drive(5'd5, 5'd6, 5'd1, 1'b1, 1'b0, 32'h100, 32'h4);
        @(negedge clock);
        check("wb_in_ready", inReady, 1'b1);
        check("read_address1", readAddress1, 5'd5);
        sb.push_back(mk(32'hDEADBEEF, 32'h1234, 5'd1, 1'b1, 1'b0, 32'h100, 32'h4, 1'b0, 1'b0));
        step();

        // MEM wins over WB for the same register; x0 always reads zero.
        memValid = 1'b1; memRdEnable = 1'b1; memIsLoad = 1'b0; memRdAddr = 5'd7; memData = 32'h11;
        wbEnable = 1'b1; wbAddr = 5'd7; wbData = 32'h22; readData1 = 32'hAAAA;
        drive(5'd0, 5'd7, 5'd2, 1'b1, 1'b0, 32'h104, 32'h0);
        sb.push_back(mk(32'h0, 32'h11, 5'd2, 1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0));
        step();
        drive(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 32'h108, 32'h0);
        sb.push_back(mk(32'h11, 32'h0, 5'd8, 1'b1, 1'b0, 32'h108, 32'h0, 1'b0, 1'b0));
        step();
        clear_pipe();
        step();
        check("idle_out_valid", outValid, 1'b0);

        // Load-use: two bubbles, then the consumer picks up the loaded value from WB.
        readData1 = 32'h50;
        drive(5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 32'h200, 32'h8);
        sb.push_back(mk(32'h50, 32'h0, 5'd3, 1'b1, 1'b1, 32'h200, 32'h8, 1'b0, 1'b0));
        step();
        readData2 = 32'h44;
        drive(5'd3, 5'd4, 5'd9, 1'b1, 1'b0, 32'h204, 32'h0);
        @(negedge clock);
        check("loaduse_ready_1", inReady, 1'b0);
        step();
        check("loaduse_bubble_1", outValid, 1'b0);
        memValid = 1'b1; memRdEnable = 1'b1; memIsLoad = 1'b1; memRdAddr = 5'd3; memData = 32'h0;
        @(negedge clock);
        check("loaduse_ready_2", inReady, 1'b0);
        step();
        check("loaduse_bubble_2", outValid, 1'b0);
        check("loaduse_count", bubbleCount, 2'd2);
        memValid = 1'b0; wbEnable = 1'b1; wbAddr = 5'd3; wbData = 32'hCAFE;
        @(negedge clock);
        check("loaduse_ready_3", inReady, 1'b1);
        sb.push_back(mk(32'hCAFE, 32'h44, 5'd9, 1'b1, 1'b0, 32'h204, 32'h0, 1'b0, 1'b0));
        step();
        wbEnable = 1'b0;

        // ALU dependence on the instruction in ID/EX: late forward flag, no stall.
        readData1 = 32'h999; readData2 = 32'h33;
        drive(5'd9, 5'd3, 5'd10, 1'b1, 1'b0, 32'h208, 32'h0);
        @(negedge clock);
        check("alu_dep_ready", inReady, 1'b1);
        sb.push_back(mk(32'h0, 32'h33, 5'd10, 1'b1, 1'b0, 32'h208, 32'h0, 1'b1, 1'b0));
        step();
        drive(5'd0, 5'd10, 5'd0, 1'b0, 1'b0, 32'h20C, 32'h0);
        sb.push_back(mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h20C, 32'h0, 1'b0, 1'b1));
        step();
        check("alu_dep_count", bubbleCount, 2'd2);

        // Backpressure: held instruction is not in the scoreboard because it gets flushed.
        readData1 = 32'h77;
        drive(5'd2, 5'd0, 5'd12, 1'b1, 1'b0, 32'h300, 32'h0);
        step();
        outReady = 1'b0;
        drive(5'd5, 5'd0, 5'd13, 1'b1, 1'b0, 32'h304, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_valid", outValid, 1'b1);
            check("hold_in_ready", inReady, 1'b0);
            check("hold_operand1", outOperand1, 32'h77);
            check("hold_pc", outPc, 32'h300);
            step();
        end
        flush = 1'b1;
        @(negedge clock);
        check("flush_in_ready", inReady, 1'b0);
        step();
        check("flush_out_valid", outValid, 1'b0);
        check("flush_count", bubbleCount, 2'd2);
        flush = 1'b0; outReady = 1'b1;
        clear_pipe();
        step();

        // Second load-use drives the 2-bit bubble counter into saturation.
        drive(5'd0, 5'd0, 5'd14, 1'b1, 1'b1, 32'h400, 32'h0);
        sb.push_back(mk(32'h0, 32'h0, 5'd14, 1'b1, 1'b1, 32'h400, 32'h0, 1'b0, 1'b0));
        step();
        drive(5'd0, 5'd14, 5'd15, 1'b1, 1'b0, 32'h404, 32'h0);
        step();
        check("sat_count_3", bubbleCount, 2'd3);
        memValid = 1'b1; memRdEnable = 1'b1; memIsLoad = 1'b1; memRdAddr = 5'd14;
        step();
        check("sat_count_hold", bubbleCount, 2'd3);
        memValid = 1'b0; wbEnable = 1'b1; wbAddr = 5'd14; wbData = 32'h1414;
        sb.push_back(mk(32'h0, 32'h1414, 5'd15, 1'b1, 1'b0, 32'h404, 32'h0, 1'b0, 1'b0));
        step();
        clear_pipe();

        // Asynchronous reset while an instruction is held.
        drive(5'd0, 5'd0, 5'd16, 1'b1, 1'b0, 32'h500, 32'h0);
        step();
        outReady = 1'b0;
        clear_pipe();
        #2 resetN = 1'b0;
        #1;
        check("async_reset_valid", outValid, 1'b0);
        check("async_reset_count", bubbleCount, 2'd0);
        check("async_reset_pc", outPc, 32'h0);
        #10 resetN = 1'b1;
        outReady = 1'b1;
        step();
        step();
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
